// File: rtl/button_conditioner_pkg.sv
// Shared types and helpers for the button conditioner: channel FSM states
// and millisecond-to-cycle conversion.
package button_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARM_PRESS,
      ST_HELD,
      ST_ARM_RELEASE
   } chan_state_e;

   // Clamped to 1 so a tiny CLK_HZ or a zero time still yields a usable count.
   function automatic int unsigned ms_to_cycles(input int unsigned clk_hz,
                                                input int unsigned ms);
      int unsigned cyc;
      cyc = clk_hz / 1000 * ms;
      return (cyc == 0) ? 32'd1 : cyc;
   endfunction

endpackage

// File: rtl/button_conditioner_channel.sv
// One button channel: 2-flop synchronizer, debounce FSM, long-press and
// auto-repeat pulse generation. All outputs are registered.
module button_channel
   import button_pkg::*;
#(
   parameter int unsigned DEB_CYC    = 1,
   parameter int unsigned LONG_CYC   = 1,
   parameter int unsigned REP_CYC    = 1,
   parameter bit          ACTIVE_LOW = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic repeat_en,
   input  logic btn_raw,
   output logic btn_level,
   output logic btn_pressed,
   output logic btn_released,
   output logic btn_long,
   output logic btn_repeat
);

   localparam int unsigned DEB_W  = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
   // Hold counter max always exceeds LONG_CYC so saturation never re-fires btn_long.
   localparam int unsigned HOLD_W = $clog2(LONG_CYC + 2);
   localparam int unsigned REP_W  = $clog2(REP_CYC + 1);

   localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEB_CYC - 1);
   localparam logic [HOLD_W-1:0] LONG_VAL = HOLD_W'(LONG_CYC);
   localparam logic [HOLD_W-1:0] LONG_PRE = HOLD_W'(LONG_CYC - 1);
   localparam logic [REP_W-1:0]  REP_VAL  = REP_W'(REP_CYC);

   logic              sync_q1, sync_q2, act;
   chan_state_e       state_q, state_d;
   logic [DEB_W-1:0]  deb_q, deb_d;
   logic [HOLD_W-1:0] hold_q, hold_d, hold_inc;
   logic [REP_W-1:0]  rep_q, rep_d, rep_inc;
   logic              past_long, rep_wrap;
   logic              level_d, pressed_d, released_d, long_d, repeat_d;

   assign act       = sync_q2 ^ ACTIVE_LOW;
   assign hold_inc  = (hold_q == '1) ? hold_q : hold_q + 1'b1;
   assign past_long = (hold_q >= LONG_VAL);
   assign rep_inc   = rep_q + 1'b1;
   assign rep_wrap  = (rep_inc == REP_VAL);

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q1      <= ACTIVE_LOW;
         sync_q2      <= ACTIVE_LOW;
         state_q      <= ST_IDLE;
         deb_q        <= '0;
         hold_q       <= '0;
         rep_q        <= '0;
         btn_level    <= 1'b0;
         btn_pressed  <= 1'b0;
         btn_released <= 1'b0;
         btn_long     <= 1'b0;
         btn_repeat   <= 1'b0;
      end else begin
         sync_q1      <= btn_raw;
         sync_q2      <= sync_q1;
         state_q      <= state_d;
         deb_q        <= deb_d;
         hold_q       <= hold_d;
         rep_q        <= rep_d;
         btn_level    <= level_d;
         btn_pressed  <= pressed_d;
         btn_released <= released_d;
         btn_long     <= long_d;
         btn_repeat   <= repeat_d;
      end
   end

   always_comb begin
      state_d = state_q;
      deb_d   = deb_q;
      hold_d  = hold_q;
      rep_d   = rep_q;
      unique case (state_q)
         ST_IDLE: begin
            if (act) begin
               state_d = ST_ARM_PRESS;
               deb_d   = '0;
            end
         end
         ST_ARM_PRESS: begin
            if (!act) begin
               state_d = ST_IDLE;
            end else if (deb_q == DEB_LAST) begin
               state_d = ST_HELD;
               hold_d  = '0;
               rep_d   = '0;
            end else begin
               deb_d = deb_q + 1'b1;
            end
         end
         ST_HELD: begin
            if (!act) begin
               state_d = ST_ARM_RELEASE;
               deb_d   = '0;
            end else begin
               hold_d = hold_inc;
               // Repeat phase keeps running with repeat_en low so re-enabling stays aligned.
               if (past_long) rep_d = rep_wrap ? '0 : rep_inc;
            end
         end
         ST_ARM_RELEASE: begin
            if (act) begin
               state_d = ST_HELD;
            end else if (deb_q == DEB_LAST) begin
               state_d = ST_IDLE;
               hold_d  = '0;
               rep_d   = '0;
            end else begin
               deb_d = deb_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      level_d    = (state_d == ST_HELD) || (state_d == ST_ARM_RELEASE);
      pressed_d  = (state_q == ST_ARM_PRESS) && (state_d == ST_HELD);
      released_d = (state_q == ST_ARM_RELEASE) && (state_d == ST_IDLE);
      long_d     = (state_q == ST_HELD) && act && (hold_q == LONG_PRE);
      repeat_d   = (state_q == ST_HELD) && act && past_long && rep_wrap && repeat_en;
   end

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel button conditioner: one independent button_channel per input
// plus an any_pressed summary of this cycle's press pulses.
module button_conditioner
   import button_pkg::*;
#(
   parameter int unsigned NUM_BUTTONS   = 4,
   parameter int unsigned CLK_HZ        = 50_000_000,
   parameter int unsigned DEBOUNCE_MS   = 20,
   parameter int unsigned LONG_PRESS_MS = 1000,
   parameter int unsigned REPEAT_MS     = 200,
   parameter bit          ACTIVE_LOW    = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_BUTTONS-1:0] repeat_en,
   input  logic [NUM_BUTTONS-1:0] btn_raw,
   output logic [NUM_BUTTONS-1:0] btn_level,
   output logic [NUM_BUTTONS-1:0] btn_pressed,
   output logic [NUM_BUTTONS-1:0] btn_released,
   output logic [NUM_BUTTONS-1:0] btn_long,
   output logic [NUM_BUTTONS-1:0] btn_repeat,
   output logic                   any_pressed
);

   localparam int unsigned DEB_CYC  = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
   localparam int unsigned LONG_CYC = ms_to_cycles(CLK_HZ, LONG_PRESS_MS);
   localparam int unsigned REP_CYC  = ms_to_cycles(CLK_HZ, REPEAT_MS);

   for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_chan
      button_channel #(
         .DEB_CYC    (DEB_CYC),
         .LONG_CYC   (LONG_CYC),
         .REP_CYC    (REP_CYC),
         .ACTIVE_LOW (ACTIVE_LOW)
      ) u_chan (
         .clk          (clk),
         .rst          (rst),
         .repeat_en    (repeat_en[i]),
         .btn_raw      (btn_raw[i]),
         .btn_level    (btn_level[i]),
         .btn_pressed  (btn_pressed[i]),
         .btn_released (btn_released[i]),
         .btn_long     (btn_long[i]),
         .btn_repeat   (btn_repeat[i])
      );
   end

   assign any_pressed = |btn_pressed;

endmodule

// File: tb/tb_button_conditioner.sv
// Testbench for button_conditioner: directed scenarios then random button
// activity, checked every cycle against a run-length reference model.
module tb_button_conditioner;

   localparam int N     = 4;
   localparam int DEB   = 5;
   localparam int LONGC = 20;
   localparam int REPC  = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] repeat_en;
   logic [N-1:0] btn_raw;
   logic [N-1:0] btn_level, btn_pressed, btn_released, btn_long, btn_repeat;
   logic         any_pressed;

   int compared   = 0;
   int mismatched = 0;

   button_conditioner #(
      .NUM_BUTTONS   (N),
      .CLK_HZ        (1000),
      .DEBOUNCE_MS   (5),
      .LONG_PRESS_MS (20),
      .REPEAT_MS     (4),
      .ACTIVE_LOW    (1'b1)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .repeat_en    (repeat_en),
      .btn_raw      (btn_raw),
      .btn_level    (btn_level),
      .btn_pressed  (btn_pressed),
      .btn_released (btn_released),
      .btn_long     (btn_long),
      .btn_repeat   (btn_repeat),
      .any_pressed  (any_pressed)
   );

   always #5 clk = ~clk;

   // Reference model: two-sample delay of the raw level, then the accepted
   // level flips after DEB+1 consecutive disagreeing samples; hold time counts
   // agreeing held samples and drives long/repeat by arithmetic.
   logic [N-1:0] m_s1 = '1, m_s2 = '1;
   bit           m_lvl  [N];
   int           m_run  [N];
   int           m_held [N];
   logic [N-1:0] exp_level = '0, exp_pressed = '0, exp_released = '0;
   logic [N-1:0] exp_long = '0, exp_repeat = '0;

   always @(posedge clk) begin
      if (rst) begin
         m_s1 = '1;
         m_s2 = '1;
         for (int ch = 0; ch < N; ch++) begin
            m_lvl[ch]  = 1'b0;
            m_run[ch]  = 0;
            m_held[ch] = 0;
         end
         exp_level = '0; exp_pressed = '0; exp_released = '0;
         exp_long  = '0; exp_repeat  = '0;
      end else begin
         for (int ch = 0; ch < N; ch++) begin
            bit a;
            a = ~m_s2[ch];
            exp_pressed[ch]  = 1'b0;
            exp_released[ch] = 1'b0;
            exp_long[ch]     = 1'b0;
            exp_repeat[ch]   = 1'b0;
            if (a != m_lvl[ch]) begin
               m_run[ch]++;
               if (m_run[ch] == DEB + 1) begin
                  m_lvl[ch]  = a;
                  m_run[ch]  = 0;
                  m_held[ch] = 0;
                  if (a) exp_pressed[ch] = 1'b1;
                  else   exp_released[ch] = 1'b1;
               end
            end else begin
               if (m_lvl[ch] && m_run[ch] == 0) begin
                  m_held[ch]++;
                  if (m_held[ch] == LONGC) exp_long[ch] = 1'b1;
                  if (m_held[ch] > LONGC && (m_held[ch] - LONGC) % REPC == 0 && repeat_en[ch])
                     exp_repeat[ch] = 1'b1;
               end
               m_run[ch] = 0;
            end
            exp_level[ch] = m_lvl[ch];
         end
         m_s2 = m_s1;
         m_s1 = btn_raw;
      end
   end

   int obs_prs [N];
   int obs_rel [N];
   int obs_long[N];
   int obs_rep [N];

   task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp_v);
      compared++;
      assert (obs === exp_v)
      else begin
         mismatched++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
      end
   endtask

   task automatic clr_counts();
      for (int ch = 0; ch < N; ch++) begin
         obs_prs[ch] = 0; obs_rel[ch] = 0; obs_long[ch] = 0; obs_rep[ch] = 0;
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk("level",    btn_level,    exp_level);
         chk("pressed",  btn_pressed,  exp_pressed);
         chk("released", btn_released, exp_released);
         chk("long",     btn_long,     exp_long);
         chk("repeat",   btn_repeat,   exp_repeat);
         chk("any",      {3'b000, any_pressed}, {3'b000, |exp_pressed});
         for (int ch = 0; ch < N; ch++) begin
            obs_prs[ch]  += int'(btn_pressed[ch]);
            obs_rel[ch]  += int'(btn_released[ch]);
            obs_long[ch] += int'(btn_long[ch]);
            obs_rep[ch]  += int'(btn_repeat[ch]);
         end
      end
   endtask

   initial begin
      int dur[N];
      int k;
      rst       = 1'b1;
      btn_raw   = '1;
      repeat_en = '0;
      clr_counts();

      // Reset state
      step(3);
      chk("rst_level", btn_level, 4'b0000);
      rst = 1'b0;
      step(5);

      // Clean press on ch0: pulse on the 8th edge after the raw change
      btn_raw[0] = 1'b0;
      step(7);
      chk("ch0_early", btn_pressed, 4'b0000);
      step(1);
      chk("ch0_press", btn_pressed, 4'b0001);
      chk("ch0_level", btn_level, 4'b0001);
      btn_raw[0] = 1'b1;
      step(12);
      chk("ch0_rel_level", btn_level, 4'b0000);

      // ch1 short glitch: no pulses
      clr_counts();
      btn_raw[1] = 1'b0;
      step(3);
      btn_raw[1] = 1'b1;
      step(10);
      chk("glitch_prs", 4'(obs_prs[1]), 4'd0);

      // ch1 press, then bouncing release
      btn_raw[1] = 1'b0;
      step(12);
      chk("ch1_held", btn_level, 4'b0010);
      clr_counts();
      btn_raw[1] = 1'b1; step(3);
      btn_raw[1] = 1'b0; step(1);
      btn_raw[1] = 1'b1; step(12);
      chk("bounce_rel", 4'(obs_rel[1]), 4'd1);
      chk("bounce_prs", 4'(obs_prs[1]), 4'd0);

      // ch2 long hold with auto-repeat
      repeat_en = 4'b0100;
      btn_raw[2] = 1'b0;
      step(7);
      step(1);
      chk("ch2_press", btn_pressed, 4'b0100);
      step(19);
      chk("ch2_long_early", btn_long, 4'b0000);
      step(1);
      chk("ch2_long", btn_long, 4'b0100);
      step(3);
      chk("ch2_rep_early", btn_repeat, 4'b0000);
      step(1);
      chk("ch2_rep4", btn_repeat, 4'b0100);
      step(3);
      step(1);
      chk("ch2_rep8", btn_repeat, 4'b0100);
      step(12);
      btn_raw[2] = 1'b1;
      step(10);

      // ch2 long hold without auto-repeat
      repeat_en = 4'b0000;
      clr_counts();
      btn_raw[2] = 1'b0;
      step(48);
      btn_raw[2] = 1'b1;
      step(10);
      chk("norep_long", 4'(obs_long[2]), 4'd1);
      chk("norep_rep", 4'(obs_rep[2]), 4'd0);

      // Simultaneous ch0 + ch3
      btn_raw = 4'b0110;
      step(7);
      step(1);
      chk("dual_press", btn_pressed, 4'b1001);
      chk("dual_any", {3'b000, any_pressed}, 4'b0001);
      step(1);
      chk("dual_any_off", {3'b000, any_pressed}, 4'b0000);
      btn_raw = 4'b1111;
      step(10);

      // Reset mid-hold with the button kept down
      btn_raw[0] = 1'b0;
      step(20);
      clr_counts();
      rst = 1'b1;
      step(3);
      chk("mid_rst_level", btn_level, 4'b0000);
      rst = 1'b0;
      step(7);
      chk("post_rst_early", btn_pressed, 4'b0000);
      step(1);
      chk("post_rst_press", btn_pressed, 4'b0001);
      chk("post_rst_norel", 4'(obs_rel[0]), 4'd0);
      btn_raw[0] = 1'b1;
      step(10);

      // Random button activity
      for (int ch = 0; ch < N; ch++) dur[ch] = $urandom_range(0, 10);
      for (int c = 0; c < 3000; c++) begin
         for (int ch = 0; ch < N; ch++) begin
            if (dur[ch] == 0) begin
               btn_raw[ch] = ~btn_raw[ch];
               dur[ch] = ($urandom % 4 == 0) ? int'($urandom_range(1, 4))
                                             : int'($urandom_range(5, 45));
            end else begin
               dur[ch]--;
            end
         end
         if ($urandom % 50 == 0) begin
            k = int'($urandom_range(0, N - 1));
            repeat_en[k] = ~repeat_en[k];
         end
         rst = ($urandom % 700 == 0);
         step(1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
